// File: rtl/render_pkg.sv
// Shared widths, FSM state encoding and attribute records for triangle setup.
package render_pkg;

  localparam int VIDX_W  = 20;
  localparam int NF_W    = 21;
  localparam int DEPTH_W = 21;
  localparam int COLOR_W = 24;
  localparam int COORD_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    LOOKUP,
    REQ,
    WAIT_SH,
    PUSH,
    DONE
  } dispatch_state_e;

  typedef struct packed {
    logic [DEPTH_W-1:0] depth;
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vtx_attr_t;

  // Vertex 1 sits in the least significant position.
  typedef struct packed {
    vtx_attr_t v3;
    vtx_attr_t v2;
    vtx_attr_t v1;
  } tri_t;

endpackage

// File: rtl/tri_dispatch_ctrl_if.sv
// Bundles the start/status, face SRAM, shader and rasterizer signals of the dispatcher.
interface tri_dispatch_ctrl_if;
  import render_pkg::*;

  logic                 enable;
  logic [NF_W-1:0]      num_of_faces;
  logic                 busy;
  logic                 finish;

  logic                 sram_rd;
  logic [VIDX_W-1:0]    sram_addr;
  logic [VIDX_W-1:0]    face_v1;
  logic [VIDX_W-1:0]    face_v2;
  logic [VIDX_W-1:0]    face_v3;

  logic                 sh_req;
  logic [VIDX_W-1:0]    sh_vidx;
  logic                 sh_ack;
  logic                 sh_done;
  logic [DEPTH_W-1:0]   sh_depth;
  logic [COLOR_W-1:0]   sh_color;
  logic [COORD_W-1:0]   sh_x;
  logic [COORD_W-1:0]   sh_y;

  logic                 tri_valid;
  logic                 tri_ready;
  logic [3*DEPTH_W-1:0] tri_depth;
  logic [3*COLOR_W-1:0] tri_color;
  logic [3*COORD_W-1:0] tri_x;
  logic [3*COORD_W-1:0] tri_y;

  modport master (
    input  enable, num_of_faces,
    input  face_v1, face_v2, face_v3,
    input  sh_ack, sh_done, sh_depth, sh_color, sh_x, sh_y,
    input  tri_ready,
    output busy, finish,
    output sram_rd, sram_addr,
    output sh_req, sh_vidx,
    output tri_valid, tri_depth, tri_color, tri_x, tri_y
  );

  modport slave (
    output enable, num_of_faces,
    output face_v1, face_v2, face_v3,
    output sh_ack, sh_done, sh_depth, sh_color, sh_x, sh_y,
    output tri_ready,
    input  busy, finish,
    input  sram_rd, sram_addr,
    input  sh_req, sh_vidx,
    input  tri_valid, tri_depth, tri_color, tri_x, tri_y
  );

endinterface

// File: rtl/tri_pingpong_buf.sv
// Two-entry triangle FIFO between the setup FSM and the rasterizer.
// A push is dropped when full; the controller only pushes below two entries.
module tri_pingpong_buf
  import render_pkg::*;
(
  input  logic       clk,
  input  logic       srst_n,
  input  logic       push,
  input  tri_t       push_data,
  input  logic       pop,
  output tri_t       head,
  output logic [1:0] count
);

  tri_t mem [2];
  logic wr_ptr;
  logic rd_ptr;
  logic do_push;
  logic do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  // Storage, wrap-around pointers and occupancy; reset discards any held triangles.
  always_ff @(posedge clk) begin
    if (srst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tri_dispatch_ctrl.sv
// Triangle setup sequencer: fetches face records, shades each vertex through a
// 3-entry round-robin vertex cache and queues finished triangles for the rasterizer.
module tri_dispatch_ctrl
  import render_pkg::*;
(
  input  logic                clk,
  input  logic                srst_n,
  tri_dispatch_ctrl_if.master bus
);

  dispatch_state_e   state_q, state_d;
  logic [NF_W-1:0]   face_cnt_q, face_cnt_d;
  logic [NF_W-1:0]   num_faces_q;
  logic [1:0]        slot_k_q, slot_k_d;

  logic [VIDX_W-1:0] face_idx [3];
  vtx_attr_t         slot_attr [3];

  logic [VIDX_W-1:0] cache_tag [3];
  vtx_attr_t         cache_attr [3];
  logic [2:0]        cache_valid;
  logic [1:0]        rr_ptr;

  logic              sram_rd_q;
  logic [VIDX_W-1:0] sram_addr_q;
  logic              sh_req_q;
  logic [VIDX_W-1:0] sh_vidx_q;
  logic              busy_q;
  logic              finish_q;
  logic              finish_d;

  logic [VIDX_W-1:0] cur_idx;
  logic              hit;
  vtx_attr_t         hit_attr;
  vtx_attr_t         sh_attr;
  logic              buf_push;
  tri_t              push_tri;
  tri_t              head_tri;
  logic [1:0]        buf_count;
  logic              tri_valid;

  assign cur_idx = face_idx[slot_k_q];

  // Tag compare of the current vertex index against the valid cache entries.
  always_comb begin
    hit      = 1'b0;
    hit_attr = '0;
    for (int i = 0; i < 3; i++) begin
      if (!hit && cache_valid[i] && (cache_tag[i] == cur_idx)) begin
        hit      = 1'b1;
        hit_attr = cache_attr[i];
      end
    end
  end

  // Collect the shader result fields into one attribute record.
  always_comb begin
    sh_attr       = '0;
    sh_attr.depth = bus.sh_depth;
    sh_attr.color = bus.sh_color;
    sh_attr.x     = bus.sh_x;
    sh_attr.y     = bus.sh_y;
  end

  // Next-state logic, face/slot counters, buffer push and done pulse.
  always_comb begin
    state_d    = state_q;
    face_cnt_d = face_cnt_q;
    slot_k_d   = slot_k_q;
    buf_push   = 1'b0;
    finish_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          face_cnt_d = '0;
          state_d    = (bus.num_of_faces == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        slot_k_d = 2'd0;
        state_d  = LOOKUP;
      end
      LOOKUP: begin
        if (!hit) begin
          state_d = REQ;
        end else if (slot_k_q == 2'd2) begin
          state_d = PUSH;
        end else begin
          slot_k_d = slot_k_q + 2'd1;
        end
      end
      REQ: begin
        if (bus.sh_ack) begin
          state_d = WAIT_SH;
        end
      end
      WAIT_SH: begin
        if (bus.sh_done) begin
          if (slot_k_q == 2'd2) begin
            state_d = PUSH;
          end else begin
            slot_k_d = slot_k_q + 2'd1;
            state_d  = LOOKUP;
          end
        end
      end
      PUSH: begin
        if (buf_count != 2'd2) begin
          buf_push   = 1'b1;
          face_cnt_d = face_cnt_q + NF_W'(1);
          state_d    = (face_cnt_d < num_faces_q) ? FETCH : DONE;
        end
      end
      DONE: begin
        if (buf_count == 2'd0) begin
          finish_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; strobes are derived from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (srst_n) begin
      state_q     <= IDLE;
      face_cnt_q  <= '0;
      num_faces_q <= '0;
      slot_k_q    <= 2'd0;
      sram_rd_q   <= 1'b0;
      sram_addr_q <= '0;
      sh_req_q    <= 1'b0;
      sh_vidx_q   <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      face_cnt_q <= face_cnt_d;
      slot_k_q   <= slot_k_d;
      if ((state_q == IDLE) && bus.enable) begin
        num_faces_q <= bus.num_of_faces;
      end
      sram_rd_q <= (state_d == FETCH);
      if (state_d == FETCH) begin
        sram_addr_q <= face_cnt_d[VIDX_W-1:0];
      end
      sh_req_q <= (state_d == REQ);
      if ((state_q == LOOKUP) && (state_d == REQ)) begin
        sh_vidx_q <= cur_idx;
      end
      busy_q   <= (state_q != IDLE) || (state_d != IDLE);
      finish_q <= finish_d;
    end
  end

  // Face capture, slot assembly and vertex cache fill (oldest entry replaced first).
  always_ff @(posedge clk) begin
    if (srst_n) begin
      cache_valid <= 3'b000;
      rr_ptr      <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        cache_tag[i]  <= '0;
        cache_attr[i] <= '0;
        slot_attr[i]  <= '0;
        face_idx[i]   <= '0;
      end
    end else begin
      if ((state_q == IDLE) && bus.enable) begin
        cache_valid <= 3'b000;
        rr_ptr      <= 2'd0;
      end
      if (state_q == WAIT_RD) begin
        face_idx[0] <= bus.face_v1;
        face_idx[1] <= bus.face_v2;
        face_idx[2] <= bus.face_v3;
      end
      if ((state_q == LOOKUP) && hit) begin
        slot_attr[slot_k_q] <= hit_attr;
      end
      if ((state_q == WAIT_SH) && bus.sh_done) begin
        slot_attr[slot_k_q]  <= sh_attr;
        cache_tag[rr_ptr]    <= cur_idx;
        cache_attr[rr_ptr]   <= sh_attr;
        cache_valid[rr_ptr]  <= 1'b1;
        rr_ptr               <= (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
      end
    end
  end

  assign push_tri.v1 = slot_attr[0];
  assign push_tri.v2 = slot_attr[1];
  assign push_tri.v3 = slot_attr[2];

  tri_pingpong_buf u_buf (
    .clk       (clk),
    .srst_n    (srst_n),
    .push      (buf_push),
    .push_data (push_tri),
    .pop       (tri_valid && bus.tri_ready),
    .head      (head_tri),
    .count     (buf_count)
  );

  assign tri_valid     = (buf_count != 2'd0);
  assign bus.tri_valid = tri_valid;
  assign bus.tri_depth = {head_tri.v3.depth, head_tri.v2.depth, head_tri.v1.depth};
  assign bus.tri_color = {head_tri.v3.color, head_tri.v2.color, head_tri.v1.color};
  assign bus.tri_x     = {head_tri.v3.x, head_tri.v2.x, head_tri.v1.x};
  assign bus.tri_y     = {head_tri.v3.y, head_tri.v2.y, head_tri.v1.y};
  assign bus.sram_rd   = sram_rd_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sh_req    = sh_req_q;
  assign bus.sh_vidx   = sh_vidx_q;
  assign bus.busy      = busy_q;
  assign bus.finish    = finish_q;

endmodule

// File: tb/tb_tri_dispatch_ctrl.sv
// Directed bench for tri_dispatch_ctrl with face SRAM, shader and rasterizer models.
module tb_tri_dispatch_ctrl;
  import render_pkg::*;

  typedef struct packed {
    logic [3*DEPTH_W-1:0] depth;
    logic [3*COLOR_W-1:0] color;
    logic [3*COORD_W-1:0] x;
    logic [3*COORD_W-1:0] y;
  } tri_obs_t;

  logic clk;
  logic srst_n;

  tri_dispatch_ctrl_if bus_if ();

  tri_dispatch_ctrl dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus_if)
  );

  int check_count;
  int pass_count;
  int sram_rd_count;
  int sh_count;
  int finish_count;
  int ack_delay;
  int sh_lat;
  int lat_cnt;
  int dly_cnt;
  logic sh_active;
  logic [VIDX_W-1:0] cur_vidx;
  logic pend;
  logic [VIDX_W-1:0] pend_addr;
  logic [VIDX_W-1:0] face_mem [16][3];
  tri_obs_t obs_q[$];
  tri_obs_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shading function: distinct attributes per vertex index.
  function automatic vtx_attr_t shade(input logic [VIDX_W-1:0] idx);
    vtx_attr_t a;
    a.depth = DEPTH_W'(({1'b0, idx} * 3) + 7);
    a.color = {4'hC, idx} ^ 24'h5A5A5A;
    a.x     = idx[11:0] + 12'd100;
    a.y     = 12'd4000 - idx[11:0];
    return a;
  endfunction

  function automatic tri_obs_t exp_tri(input logic [VIDX_W-1:0] a, input logic [VIDX_W-1:0] b,
                                       input logic [VIDX_W-1:0] c);
    vtx_attr_t p;
    vtx_attr_t q;
    vtx_attr_t r;
    tri_obs_t t;
    p = shade(a);
    q = shade(b);
    r = shade(c);
    t.depth = {r.depth, q.depth, p.depth};
    t.color = {r.color, q.color, p.color};
    t.x     = {r.x, q.x, p.x};
    t.y     = {r.y, q.y, p.y};
    return t;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic add_face(input int n, input int a, input int b, input int c);
    face_mem[n][0] = VIDX_W'(a);
    face_mem[n][1] = VIDX_W'(b);
    face_mem[n][2] = VIDX_W'(c);
    exp_q.push_back(exp_tri(VIDX_W'(a), VIDX_W'(b), VIDX_W'(c)));
  endtask

  task automatic clear_counters();
    sram_rd_count = 0;
    sh_count      = 0;
    finish_count  = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Enable is high during cycle 0; returns in the middle of cycle 1.
  task automatic apply_stimulus(input int n);
    bus_if.num_of_faces = NF_W'(n);
    bus_if.enable       = 1'b1;
    @(negedge clk);
    bus_if.enable       = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int budget);
    int n;
    n = 0;
    while (bus_if.finish !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, bus_if.finish, 1'b1);
  endtask

  task automatic compare_tris(input string tag);
    check_output($sformatf("%s_tri_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_output($sformatf("%s_depth%0d", tag, i), obs_q[i].depth, exp_q[i].depth);
      check_output($sformatf("%s_color%0d", tag, i), obs_q[i].color, exp_q[i].color);
      check_output($sformatf("%s_x%0d", tag, i), obs_q[i].x, exp_q[i].x);
      check_output($sformatf("%s_y%0d", tag, i), obs_q[i].y, exp_q[i].y);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_sram_rd"}, bus_if.sram_rd, 1'b0);
    check_output({tag, "_sram_addr"}, bus_if.sram_addr, '0);
    check_output({tag, "_sh_req"}, bus_if.sh_req, 1'b0);
    check_output({tag, "_sh_vidx"}, bus_if.sh_vidx, '0);
    check_output({tag, "_tri_valid"}, bus_if.tri_valid, 1'b0);
    check_output({tag, "_busy"}, bus_if.busy, 1'b0);
    check_output({tag, "_finish"}, bus_if.finish, 1'b0);
    check_output({tag, "_tri_data"}, {bus_if.tri_depth, bus_if.tri_x}, '0);
    check_output({tag, "_tri_cy"}, {bus_if.tri_color, bus_if.tri_y}, '0);
  endtask

  // Face SRAM: data appears the cycle after the read strobe.
  initial begin
    pend           = 1'b0;
    pend_addr      = '0;
    bus_if.face_v1 = '0;
    bus_if.face_v2 = '0;
    bus_if.face_v3 = '0;
    forever begin
      @(negedge clk);
      if (srst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          bus_if.face_v1 = face_mem[pend_addr[3:0]][0];
          bus_if.face_v2 = face_mem[pend_addr[3:0]][1];
          bus_if.face_v3 = face_mem[pend_addr[3:0]][2];
        end
        pend      = bus_if.sram_rd;
        pend_addr = bus_if.sram_addr;
      end
    end
  end

  // Shader: acks after ack_delay cycles of sh_req, returns a result sh_lat cycles later.
  initial begin
    bus_if.sh_ack   = 1'b0;
    bus_if.sh_done  = 1'b0;
    bus_if.sh_depth = '0;
    bus_if.sh_color = '0;
    bus_if.sh_x     = '0;
    bus_if.sh_y     = '0;
    sh_active       = 1'b0;
    lat_cnt         = 0;
    dly_cnt         = 0;
    cur_vidx        = '0;
    forever begin
      @(negedge clk);
      if (srst_n) begin
        bus_if.sh_ack  = 1'b0;
        bus_if.sh_done = 1'b0;
        sh_active      = 1'b0;
        dly_cnt        = 0;
      end else begin
        bus_if.sh_done = 1'b0;
        if (bus_if.sh_ack) begin
          bus_if.sh_ack = 1'b0;
          sh_active     = 1'b1;
          lat_cnt       = sh_lat;
        end else if (sh_active) begin
          lat_cnt--;
          if (lat_cnt <= 0) begin
            sh_active       = 1'b0;
            bus_if.sh_depth = shade(cur_vidx).depth;
            bus_if.sh_color = shade(cur_vidx).color;
            bus_if.sh_x     = shade(cur_vidx).x;
            bus_if.sh_y     = shade(cur_vidx).y;
            bus_if.sh_done  = 1'b1;
          end
        end else if (bus_if.sh_req) begin
          if (dly_cnt >= ack_delay) begin
            bus_if.sh_ack = 1'b1;
            cur_vidx      = bus_if.sh_vidx;
            sh_count++;
            dly_cnt       = 0;
          end else begin
            dly_cnt++;
          end
        end
      end
    end
  end

  // Monitor: counts strobes and records accepted triangles just after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!srst_n) begin
        if (bus_if.sram_rd) sram_rd_count++;
        if (bus_if.finish) finish_count++;
        if (bus_if.tri_valid && bus_if.tri_ready) begin
          obs_q.push_back({bus_if.tri_depth, bus_if.tri_color, bus_if.tri_x, bus_if.tri_y});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_count         = 0;
    pass_count          = 0;
    srst_n              = 1'b1;
    bus_if.enable       = 1'b0;
    bus_if.num_of_faces = '0;
    bus_if.tri_ready    = 1'b1;
    ack_delay           = 0;
    sh_lat              = 4;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 3; j++) face_mem[i][j] = '0;
    end
    clear_counters();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    srst_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] zero-face start");
    clear_counters();
    apply_stimulus(0);
    check_output("zero_busy_c1", bus_if.busy, 1'b1);
    check_output("zero_finish_c1", bus_if.finish, 1'b0);
    @(negedge clk);
    check_output("zero_finish_c2", bus_if.finish, 1'b1);
    @(negedge clk);
    check_output("zero_finish_c3", bus_if.finish, 1'b0);
    check_output("zero_busy_c3", bus_if.busy, 1'b0);
    check_output("zero_sram_rd", sram_rd_count, 0);
    check_output("zero_sh_req", sh_count, 0);

    $display("[TB] single face");
    clear_counters();
    add_face(0, 5, 6, 7);
    ack_delay = 0;
    sh_lat    = 4;
    apply_stimulus(1);
    check_output("one_sram_rd_c1", bus_if.sram_rd, 1'b1);
    check_output("one_sram_addr_c1", bus_if.sram_addr, '0);
    @(negedge clk);
    check_output("one_sram_rd_c2", bus_if.sram_rd, 1'b0);
    wait_finish("one_finish_seen", 200);
    repeat (2) @(negedge clk);
    check_output("one_sh_count", sh_count, 3);
    check_output("one_finish_count", finish_count, 1);
    check_output("one_busy_idle", bus_if.busy, 1'b0);
    if (obs_q.size() > 0)
      check_output("one_v1_depth", obs_q[0].depth[DEPTH_W-1:0], shade(VIDX_W'(5)).depth);
    compare_tris("one");

    $display("[TB] triangle strip");
    clear_counters();
    add_face(0, 0, 1, 2);
    add_face(1, 1, 2, 3);
    add_face(2, 2, 3, 4);
    ack_delay = 2;
    sh_lat    = 3;
    apply_stimulus(3);
    wait_finish("strip_finish_seen", 400);
    repeat (2) @(negedge clk);
    check_output("strip_sh_count", sh_count, 5);
    check_output("strip_sram_rd_count", sram_rd_count, 3);
    compare_tris("strip");

    $display("[TB] back-pressure stall");
    clear_counters();
    bus_if.tri_ready = 1'b0;
    add_face(0, 10, 11, 12);
    add_face(1, 13, 14, 15);
    add_face(2, 16, 17, 18);
    add_face(3, 19, 20, 21);
    ack_delay = 0;
    sh_lat    = 2;
    apply_stimulus(4);
    repeat (150) @(negedge clk);
    check_output("stall_tri_valid", bus_if.tri_valid, 1'b1);
    check_output("stall_busy", bus_if.busy, 1'b1);
    check_output("stall_no_finish", finish_count, 0);
    check_output("stall_no_pop", obs_q.size(), 0);
    check_output("stall_sh_count", sh_count, 9);
    check_output("stall_sram_rd_count", sram_rd_count, 3);
    bus_if.tri_ready = 1'b1;
    wait_finish("stall_finish_seen", 300);
    repeat (2) @(negedge clk);
    check_output("stall_finish_count", finish_count, 1);
    check_output("stall_sh_total", sh_count, 12);
    compare_tris("stall");

    $display("[TB] repeated vertex");
    clear_counters();
    add_face(0, 9, 9, 9);
    apply_stimulus(1);
    wait_finish("dup_finish_seen", 200);
    repeat (2) @(negedge clk);
    check_output("dup_sh_count", sh_count, 1);
    compare_tris("dup");

    $display("[TB] reset during shading");
    clear_counters();
    bus_if.tri_ready = 1'b0;
    add_face(0, 30, 31, 32);
    add_face(1, 33, 34, 35);
    sh_lat = 6;
    apply_stimulus(2);
    begin
      int n;
      n = 0;
      while (sh_count < 4 && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    check_output("rst_reached_face2", sh_count >= 4, 1'b1);
    repeat (2) @(negedge clk);
    check_output("rst_pre_tri_valid", bus_if.tri_valid, 1'b1);
    srst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("midrst");
    srst_n           = 1'b0;
    bus_if.tri_ready = 1'b1;
    clear_counters();
    add_face(0, 40, 30, 41);
    sh_lat    = 3;
    ack_delay = 1;
    @(negedge clk);
    apply_stimulus(1);
    wait_finish("post_rst_finish_seen", 300);
    repeat (2) @(negedge clk);
    check_output("post_rst_sh_count", sh_count, 3);
    compare_tris("post_rst");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
